// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants, FSM state types and the parity helper for the UART.
// No ports; imported by uart and uart_bit_timer.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Bit period in clk cycles and the offset used to land RX samples mid-bit.
  localparam int unsigned CLKS_PER_BIT = 16;
  localparam int unsigned HALF_BIT     = 8;

  // Width of the per-bit cycle counter (0..CLKS_PER_BIT-1).
  localparam int unsigned CNT_W = 4;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  localparam int unsigned PAR_MAX_W = 32;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Free-running 0..CLKS_PER_BIT-1 cycle counter that pulses tick_o on its last
// count. While clear_i is high the counter is held at load_val_i, which lets the
// RX path start half a bit in so its ticks fall mid-bit.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   clear_i    : hold counter at load_val_i (no tick while high)
//   load_val_i : value loaded while clear_i is high
//   tick_o     : one-cycle pulse when the counter sits on its last count
// -----------------------------------------------------------------------------
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load, wrap at the end of a bit, or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart.sv
// -----------------------------------------------------------------------------
// uart
// Full-duplex UART with a fixed 16-cycle bit period. Frame: start(0), data LSB
// first, even parity, stop(1). TX and RX are independent.
//   clk           : system clock, all state on the rising edge
//   reset         : asynchronous active-low reset
//   SerialDataIn  : RX line (idles high, synchronized internally)
//   Clear_RX_Flag : synchronous clear of RX_FLAG and ParityError
//   DATATX        : word to transmit, latched on a Transmit rising edge
//   Transmit      : transmit request (edge sensitive, ignored while busy)
//   DATARX        : last received word
//   RX_FLAG       : a received word is available
//   SerialDataOut : TX line (idles high)
//   ParityError   : parity mismatch on the last received frame
// -----------------------------------------------------------------------------
module uart
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   SerialDataIn,
  input  logic                   Clear_RX_Flag,
  input  logic [WORD_LENGTH-1:0] DATATX,
  input  logic                   Transmit,
  output logic [WORD_LENGTH-1:0] DATARX,
  output logic                   RX_FLAG,
  output logic                   SerialDataOut,
  output logic                   ParityError
);

  localparam int IDX_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LENGTH - 1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e              tx_state_q, tx_state_d;
  logic [WORD_LENGTH-1:0] tx_data_q, tx_data_d;
  logic [IDX_W-1:0]       tx_idx_q, tx_idx_d;
  logic                   tx_prev_q;          // Transmit one cycle ago
  logic                   tx_out_q, tx_out_d;
  logic                   tx_tick;

  // Timer held at 0 in IDLE so START lasts a full bit from the trigger edge.
  uart_bit_timer u_tx_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (tx_state_q == TX_IDLE),
    .load_val_i (CNT_W'(0)),
    .tick_o     (tx_tick)
  );

  // TX next state; the line value is derived from the next state so the
  // output register changes on the same edge as the state.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_idx_d   = tx_idx_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (Transmit && !tx_prev_q) begin
          tx_state_d = TX_START;
          tx_data_d  = DATATX;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_idx_d   = {IDX_W{1'b0}};
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_tick && (tx_idx_q == IDX_LAST)) begin
          tx_state_d = TX_PARITY;
        end else if (tx_tick) begin
          tx_idx_d = tx_idx_q + IDX_W'(1);
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (tx_tick) begin
          tx_state_d = TX_STOP;
        end else begin
          tx_state_d = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_state_d = TX_IDLE;
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
      end
    endcase

    tx_out_d = 1'b1;
    case (tx_state_d)
      TX_IDLE:   tx_out_d = 1'b1;
      TX_START:  tx_out_d = 1'b0;
      TX_DATA:   tx_out_d = tx_data_d[tx_idx_d];
      TX_PARITY: tx_out_d = even_parity(PAR_MAX_W'(tx_data_d));
      TX_STOP:   tx_out_d = 1'b1;
      default:   tx_out_d = 1'b1;
    endcase
  end

  // TX state, data latch, edge history and line register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_data_q  <= {WORD_LENGTH{1'b1}};
      tx_idx_q   <= {IDX_W{1'b0}};
      tx_prev_q  <= 1'b1;   // a Transmit held high through reset is not an edge
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      tx_idx_q   <= tx_idx_d;
      tx_prev_q  <= Transmit;
      tx_out_q   <= tx_out_d;
    end
  end

  assign SerialDataOut = tx_out_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  rx_state_e              rx_state_q, rx_state_d;
  logic                   rx_sync1_q, rx_sync2_q;
  logic                   rx_prev_q;          // synchronized line one cycle ago
  logic [IDX_W-1:0]       rx_idx_q, rx_idx_d;
  logic [WORD_LENGTH-1:0] rx_shift_q, rx_shift_d;
  logic                   rx_par_q, rx_par_d;
  logic [WORD_LENGTH-1:0] rx_data_q, rx_data_d;
  logic                   rx_flag_q, rx_flag_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_tick;
  logic                   rx_fall;
  logic                   rx_done;

  // Preloading HALF_BIT puts the first tick half a bit after the falling edge;
  // every later tick is then a full bit on, near the middle of each bit.
  uart_bit_timer u_rx_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (rx_state_q == RX_IDLE),
    .load_val_i (CNT_W'(HALF_BIT)),
    .tick_o     (rx_tick)
  );

  assign rx_fall = rx_prev_q && !rx_sync2_q;

  // RX next state, shift register and result registers.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_tick && rx_sync2_q) begin
          rx_state_d = RX_IDLE;       // line back high: false start
        end else if (rx_tick) begin
          rx_state_d = RX_DATA;
          rx_idx_d   = {IDX_W{1'b0}};
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          // LSB arrives first, so shift in from the top.
          rx_shift_d = (rx_shift_q >> 1) |
                       (WORD_LENGTH'(rx_sync2_q) << (WORD_LENGTH - 1));
          if (rx_idx_q == IDX_LAST) begin
            rx_state_d = RX_PARITY;
          end else begin
            rx_idx_d = rx_idx_q + IDX_W'(1);
          end
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_par_d   = rx_sync2_q;
          rx_state_d = RX_STOP;
        end else begin
          rx_state_d = RX_PARITY;
        end
      end
      RX_STOP: begin
        // The stop bit value is not checked; the word is delivered regardless.
        if (rx_tick) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase

    rx_data_d = rx_data_q;
    rx_flag_d = rx_flag_q;
    rx_perr_d = rx_perr_q;
    // A completing frame takes priority over a simultaneous clear.
    if (rx_done) begin
      rx_data_d = rx_shift_q;
      rx_flag_d = 1'b1;
      rx_perr_d = rx_par_q ^ even_parity(PAR_MAX_W'(rx_shift_q));
    end else if (Clear_RX_Flag) begin
      rx_flag_d = 1'b0;
      rx_perr_d = 1'b0;
    end else begin
      rx_flag_d = rx_flag_q;
    end
  end

  // RX synchronizer, FSM and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_idx_q   <= {IDX_W{1'b0}};
      rx_shift_q <= {WORD_LENGTH{1'b0}};
      rx_par_q   <= 1'b0;
      rx_data_q  <= {WORD_LENGTH{1'b0}};
      rx_flag_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_sync1_q <= SerialDataIn;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_flag_q  <= rx_flag_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  assign DATARX      = rx_data_q;
  assign RX_FLAG     = rx_flag_q;
  assign ParityError = rx_perr_q;

endmodule

// File: tb/tb_uart.sv
// -----------------------------------------------------------------------------
// tb_uart
// Scoreboard bench for uart: stimulus pushes expected TX frames / RX results
// into queues; independent monitors pop and compare when the DUT produces
// a TX start bit or raises RX_FLAG.
// -----------------------------------------------------------------------------
module tb_uart;

  logic       clk = 1'b0;
  logic       reset;
  logic       SerialDataIn;
  logic       Clear_RX_Flag;
  logic [7:0] DATATX;
  logic       Transmit;
  logic [7:0] DATARX;
  logic       RX_FLAG;
  logic       SerialDataOut;
  logic       ParityError;

  int total = 0;
  int bad   = 0;

  // TX expectation: bit i is the i-th serial bit (start..stop) plus one idle bit.
  logic [11:0] tx_exp_q[$];
  // RX expectation: {ParityError, DATARX}.
  logic [8:0]  rx_exp_q[$];

  uart #(.WORD_LENGTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .SerialDataIn  (SerialDataIn),
    .Clear_RX_Flag (Clear_RX_Flag),
    .DATATX        (DATATX),
    .Transmit      (Transmit),
    .DATARX        (DATARX),
    .RX_FLAG       (RX_FLAG),
    .SerialDataOut (SerialDataOut),
    .ParityError   (ParityError)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one RX frame: start, data LSB first, parity bit p, stop bit s.
  task automatic rx_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      SerialDataIn = f[i];
      tick(16);
    end
  endtask

  task automatic clear_pulse();
    Clear_RX_Flag = 1'b1;
    tick(1);
    Clear_RX_Flag = 1'b0;
  endtask

  // TX monitor: on each start bit, sample every bit mid-period.
  initial begin : tx_mon
    logic [11:0] exp;
    bit          aborted;
    forever begin
      @(negedge SerialDataOut);
      if (tx_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected_frame: got a start bit, expected no frame");
        repeat (176) @(posedge clk);
      end else begin
        exp     = tx_exp_q.pop_front();
        aborted = 1'b0;
        for (int i = 0; i < 12 && !aborted; i++) begin
          for (int c = 0; c < ((i == 0) ? 8 : 16); c++) begin
            @(posedge clk);
            if (!reset) aborted = 1'b1;
          end
          #1;
          if (!aborted) chk($sformatf("tx_bit%0d", i), 32'(SerialDataOut), 32'(exp[i]));
        end
      end
    end
  end

  // RX monitor: each time RX_FLAG rises, compare the delivered word.
  initial begin : rx_mon
    logic [8:0] exp;
    forever begin
      @(posedge RX_FLAG);
      @(negedge clk);
      if (rx_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected_word: got DATARX=%0h, expected no word", DATARX);
      end else begin
        exp = rx_exp_q.pop_front();
        chk("rx_flag", 32'(RX_FLAG), 32'd1);
        chk("rx_data", 32'(DATARX), 32'(exp[7:0]));
        chk("rx_perr", 32'(ParityError), 32'(exp[8]));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    reset         = 1'b0;
    SerialDataIn  = 1'b1;
    Clear_RX_Flag = 1'b0;
    Transmit      = 1'b0;
    DATATX        = 8'h00;
    tick(3);
    chk("rst_txd",   32'(SerialDataOut), 32'd1);
    chk("rst_data",  32'(DATARX),        32'd0);
    chk("rst_flag",  32'(RX_FLAG),       32'd0);
    chk("rst_perr",  32'(ParityError),   32'd0);
    reset = 1'b1;
    tick(5);

    // TX 0x07, one-cycle request: 0,1,1,1,0,0,0,0,0,par 1,stop 1,idle 1.
    tx_exp_q.push_back(12'b111000001110);
    DATATX   = 8'h07;
    Transmit = 1'b1;
    tick(1);
    Transmit = 1'b0;
    tick(200);

    // RX 0x69, correct parity.
    rx_exp_q.push_back({1'b0, 8'h69});
    rx_frame(8'h69, 1'b0, 1'b1);
    tick(4);
    clear_pulse();
    chk("clr_flag", 32'(RX_FLAG),     32'd0);
    chk("clr_perr", 32'(ParityError), 32'd0);
    chk("clr_data", 32'(DATARX),      32'h69);

    // RX 0x99 with wrong parity, concurrent with TX 0xA5 while Transmit stays high.
    fork
      begin
        rx_exp_q.push_back({1'b1, 8'h99});
        rx_frame(8'h99, 1'b1, 1'b1);
      end
      begin
        tx_exp_q.push_back(12'b110101001010);
        DATATX   = 8'hA5;
        Transmit = 1'b1;
        tick(200);
        Transmit = 1'b0;
      end
    join
    tick(40);
    clear_pulse();
    chk("clr2_flag", 32'(RX_FLAG),     32'd0);
    chk("clr2_perr", 32'(ParityError), 32'd0);

    // Stop bit sampled low still delivers; then overwrite with flag still set.
    rx_exp_q.push_back({1'b0, 8'h01});
    rx_frame(8'h01, 1'b1, 1'b0);
    SerialDataIn = 1'b1;
    tick(16);
    rx_frame(8'hFF, 1'b0, 1'b1);
    tick(4);
    chk("ovw_data", 32'(DATARX),      32'hFF);
    chk("ovw_flag", 32'(RX_FLAG),     32'd1);
    chk("ovw_perr", 32'(ParityError), 32'd0);

    // Clear held high across a completing frame: the set wins for that cycle.
    Clear_RX_Flag = 1'b1;
    rx_exp_q.push_back({1'b0, 8'h5A});
    rx_frame(8'h5A, 1'b0, 1'b1);
    Clear_RX_Flag = 1'b0;
    tick(2);
    chk("setwin_flag_after", 32'(RX_FLAG), 32'd0);

    // 4-cycle low glitch: no frame.
    SerialDataIn = 1'b0;
    tick(4);
    SerialDataIn = 1'b1;
    tick(200);
    chk("glitch_flag", 32'(RX_FLAG), 32'd0);
    chk("glitch_data", 32'(DATARX),  32'h5A);

    // Reset in the middle of TX 0xF0 (during frame bit 4, a 0 on the line).
    tx_exp_q.push_back(12'b110111100000);
    DATATX   = 8'hF0;
    Transmit = 1'b1;
    tick(1);
    Transmit = 1'b0;
    tick(71);
    chk("abort_before", 32'(SerialDataOut), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_txd", 32'(SerialDataOut), 32'd1);
    tick(3);
    chk("abort_data", 32'(DATARX), 32'd0);
    reset = 1'b1;
    tick(5);

    // A fresh request after the abort sends a complete frame.
    tx_exp_q.push_back(12'b110101001010);
    DATATX   = 8'hA5;
    Transmit = 1'b1;
    tick(1);
    Transmit = 1'b0;
    tick(220);

    chk("tx_queue_empty", 32'(tx_exp_q.size()), 32'd0);
    chk("rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter WORD_LENGTH, default 8: data bits per frame.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 SerialDataIn  input  1  RX serial line; idles high.
REQ-005 Clear_RX_Flag  input  1  synchronous clear of RX_FLAG and ParityError.
REQ-006 DATATX  input  WORD_LENGTH  transmit data word.
REQ-007 Transmit  input  1  transmit request.
REQ-008 DATARX  output  WORD_LENGTH  last received data word.
REQ-009 RX_FLAG  output  1  high when a received word is available.
REQ-010 SerialDataOut  output  1  TX serial line; idles high.
REQ-011 ParityError  output  1  parity mismatch on the last received frame.

Function
REQ-012 The frame SHALL be: start bit 0, WORD_LENGTH data bits LSB first, one even-parity bit, one stop bit 1.
REQ-013 Bit period SHALL be fixed at 16 clk cycles (CLKS_PER_BIT=16), so a frame is 176 cycles.
REQ-014 Even parity: the parity bit SHALL equal the XOR of all data bits.
REQ-015 TX states SHALL be IDLE, START, DATA, PARITY, STOP; each non-IDLE bit lasts exactly 16 cycles.
REQ-016 In IDLE, a Transmit rising edge SHALL latch DATATX and enter START on the next cycle.
REQ-017 Transmit edges arriving while TX is not IDLE SHALL be ignored; TX SHALL NOT re-trigger while Transmit stays high.
REQ-018 At the end of STOP, TX SHALL return to IDLE with SerialDataOut=1.
REQ-019 SerialDataIn SHALL pass through a 2-flop synchronizer before any use.
REQ-020 RX states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 RX SHALL leave IDLE on a synchronized high-to-low transition.
REQ-022 In START, RX SHALL resample the line 8 cycles after the falling edge and return to IDLE if it is high (false start).
REQ-023 Data, parity and stop bits SHALL each be sampled every 16 cycles after the mid-start sample.
REQ-024 At the stop-bit sample, RX SHALL load DATARX, set RX_FLAG=1, and set ParityError=1 exactly when the received parity bit differs from the XOR of the data bits (otherwise 0), then return to IDLE.
REQ-025 A stop bit sampled as 0 SHALL still deliver the word; no framing-error output exists.
REQ-026 DATARX, RX_FLAG and ParityError SHALL hold until the next completed frame; RX_FLAG and ParityError clear only via Clear_RX_Flag or reset.
REQ-027 When Clear_RX_Flag is high in the same cycle as a frame completes, the set SHALL win.
REQ-028 A new frame SHALL overwrite DATARX even if RX_FLAG is still high.
REQ-029 The TX and RX paths SHALL be fully independent and operate concurrently.

Reset
REQ-030 While reset=0, both FSMs SHALL be in IDLE with counters at 0, SerialDataOut=1, DATARX=0, RX_FLAG=0, ParityError=0, and the TX latch and synchronizer flops set to 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, with no partial delivery.

Structure
REQ-032 Package uart_pkg SHALL hold CLKS_PER_BIT=16, HALF_BIT=8 and the TX/RX state enum typedefs.
REQ-033 One sub-module, uart_bit_timer (a 0..15 cycle counter with a bit-tick output), SHALL be instantiated once in TX and once in RX; all other logic stays in uart.

Verification
REQ-034 Reset, then DATATX=0x07 with a one-cycle Transmit pulse -> SerialDataOut carries 0,1,1,1,0,0,0,0,0,1(parity),1, each bit 16 cycles, then idles high.
REQ-035 RX frame with data bits (LSB first) 1,0,0,1,0,1,1,0, parity 0, stop 1 -> DATARX=0x69, RX_FLAG=1, ParityError=0.
REQ-036 Pulse Clear_RX_Flag after REQ-035 -> RX_FLAG=0 and ParityError=0, DATARX stays 0x69.
REQ-037 RX frame with data bits 1,0,0,1,1,0,0,1, parity 1 -> DATARX=0x99, RX_FLAG=1, ParityError=1.
REQ-038 Low glitch on SerialDataIn of 4 cycles -> no frame, RX_FLAG stays 0.
REQ-039 Assert reset mid-TX at bit 4 -> SerialDataOut=1 immediately; a new Transmit then sends a complete frame.
